// File: rtl/rmw_mask_mem.sv
// rmw_mask_mem: single-port scratch memory with byte-masked read-modify-write.
// After reset the array is swept to zero, one word per cycle, before requests
// are accepted. Each accepted request returns the pre-operation word one cycle
// after acceptance and writes the merged result at the end of that cycle.
//
// Handshake: a request transfers on a rising edge where io_req_valid and
// io_req_ready are both 1. io_req_ready is 1 throughout RUN and 0 during the
// sweep. io_resp_valid is a one-cycle pulse per transferred request with no
// back-pressure; io_resp_data holds its last value between pulses.
module rmw_mask_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [1:0]        io_req_op,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,
  input  logic [NB-1:0]     io_req_mask,
  output logic              io_resp_valid,
  output logic [DATA_W-1:0] io_resp_data,
  output logic              io_busy
);

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_KEEP  = 2'd2;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Stage-2 copy of the accepted request; the old word lives in resp_data_q.
  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [1:0]        p_op;
  logic [DATA_W-1:0] p_wdata;
  logic [NB-1:0]     p_mask;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;

  logic              accept;
  logic              p_write;
  logic [DATA_W-1:0] p_m;
  logic [DATA_W-1:0] p_new;
  logic [DATA_W-1:0] rd_old;

  assign io_req_ready  = (state == ST_RUN);
  assign io_busy       = (state == ST_SWEEP);
  assign io_resp_valid = resp_valid_q;
  assign io_resp_data  = resp_data_q;
  assign accept        = io_req_valid && io_req_ready;

  // Stage-2 merge: expand the byte mask, decide whether a write happens and
  // form the new word from the old word held in the response register.
  always_comb begin
    p_m = '0;
    for (int i = 0; i < NB; i++) begin
      p_m[8*i +: 8] = {8{p_mask[i]}};
    end
    p_write = p_valid && ((p_op == OP_WRITE) || (p_op == OP_KEEP)) && (p_mask != '0);
    if (p_op == OP_WRITE) begin
      p_new = (p_wdata & p_m) | (resp_data_q & ~p_m);
    end else begin
      p_new = resp_data_q & p_m;
    end
  end

  // Old-value select for an incoming request: a same-address write still in
  // stage 2 has not reached the array yet, so its result is forwarded.
  always_comb begin
    rd_old = mem[io_req_addr];
    if (p_write && (p_addr == io_req_addr)) begin
      rd_old = p_new;
    end
  end

  // Control state: sweep/run FSM, pipeline valid and the response register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_SWEEP;
      sweep_cnt    <= '0;
      p_valid      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      p_valid      <= accept;
      resp_valid_q <= accept;
      if (accept) begin
        resp_data_q <= rd_old;
      end
      if (state == ST_SWEEP) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_cnt == ADDR_W'(DEPTH - 1)) begin
          state <= ST_RUN;
        end
      end
    end
  end

  // Stage-2 request fields; only meaningful while p_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      p_addr  <= io_req_addr;
      p_op    <= io_req_op;
      p_wdata <= io_req_wdata;
      p_mask  <= io_req_mask;
    end
  end

  // Array write port: zeroing sweep, otherwise the stage-2 merge result.
  // A pending write is dropped when reset is sampled low.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_SWEEP) begin
        mem[sweep_cnt] <= '0;
      end else if (p_write) begin
        mem[p_addr] <= p_new;
      end
    end
  end

endmodule

// File: tb/tb_rmw_mask_mem.sv
// Testbench for rmw_mask_mem (DATA_W=32, DEPTH=8).
module tb_rmw_mask_mem;

  logic        clk;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [1:0]  io_req_op;
  logic [2:0]  io_req_addr;
  logic [31:0] io_req_wdata;
  logic [3:0]  io_req_mask;
  logic        io_resp_valid;
  logic [31:0] io_resp_data;
  logic        io_busy;

  rmw_mask_mem #(.DATA_W(32), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_req_op    (io_req_op),
    .io_req_addr  (io_req_addr),
    .io_req_wdata (io_req_wdata),
    .io_req_mask  (io_req_mask),
    .io_resp_valid(io_resp_valid),
    .io_resp_data (io_resp_data),
    .io_busy      (io_busy)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bookkeeping
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] model [8];

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
  endtask

  // Independent byte-wise reference of the merge rules.
  task automatic model_update(input logic [1:0] op, input logic [2:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask);
    logic [31:0] w;
    if ((op == 2'd1 || op == 2'd2) && mask != 4'h0) begin
      w = model[addr];
      for (int b = 0; b < 4; b++) begin
        if (op == 2'd1) begin
          if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end else begin
          if (!mask[b]) w[8*b +: 8] = 8'h00;
        end
      end
      model[addr] = w;
    end
  endtask

  // driver: present one request, wait (bounded) for ready, push expectation
  task automatic send(input logic [1:0] op, input logic [2:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp);
    int n = 0;
    io_req_valid = 1'b1;
    io_req_op    = op;
    io_req_addr  = addr;
    io_req_wdata = wdata;
    io_req_mask  = mask;
    @(negedge clk);
    while (!io_req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!io_req_ready) begin
      chk("req_ready_timeout", {31'b0, io_req_ready}, 32'h1);
    end else begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 1);
      model_update(op, addr, wdata, mask);
    end
    @(posedge clk);
    #1;
    io_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count busy cycles after reset deassertion; expect exactly 8, then ready.
  task automatic wait_sweep(input string name);
    int n = 0;
    @(negedge clk);
    while (io_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, n, 32'd8);
    chk({name, "_ready"}, {31'b0, io_req_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 8; a++) send(2'd0, 3'(a), 32'h0, 4'h0, 32'h0);
  endtask

  // scoreboard: every response pulse pops one expectation
  always @(negedge clk) begin
    if (io_resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_resp_valid", 32'h1, 32'h0);
      end else begin
        chk("resp_data", io_resp_data, exp_q.pop_front());
        chk("resp_latency", cyc, cyc_q.pop_front());
      end
    end
  end

  initial begin
    tbl[0]  = '{2'd1, 3'd3, 32'hAABBCCDD, 4'hF, 32'h00000000};
    tbl[1]  = '{2'd0, 3'd3, 32'h00000000, 4'h0, 32'hAABBCCDD};
    tbl[2]  = '{2'd1, 3'd5, 32'h11223344, 4'hF, 32'h00000000};
    tbl[3]  = '{2'd1, 3'd5, 32'hFFFFFFFF, 4'h5, 32'h11223344};
    tbl[4]  = '{2'd0, 3'd5, 32'h00000000, 4'h0, 32'h11FF33FF};
    tbl[5]  = '{2'd1, 3'd2, 32'hDEADBEEF, 4'hF, 32'h00000000};
    tbl[6]  = '{2'd2, 3'd2, 32'h00000000, 4'h3, 32'hDEADBEEF};
    tbl[7]  = '{2'd0, 3'd2, 32'h00000000, 4'h0, 32'h0000BEEF};
    tbl[8]  = '{2'd3, 3'd3, 32'h12121212, 4'hF, 32'hAABBCCDD};
    tbl[9]  = '{2'd0, 3'd3, 32'h00000000, 4'h0, 32'hAABBCCDD};
    tbl[10] = '{2'd1, 3'd3, 32'h00000000, 4'h0, 32'hAABBCCDD};
    tbl[11] = '{2'd0, 3'd3, 32'h00000000, 4'h0, 32'hAABBCCDD};
    tbl[12] = '{2'd2, 3'd5, 32'h00000000, 4'h0, 32'h11FF33FF};
    tbl[13] = '{2'd0, 3'd5, 32'h00000000, 4'h0, 32'h11FF33FF};

    reset        = 1'b0;
    io_req_valid = 1'b0;
    io_req_op    = 2'd0;
    io_req_addr  = 3'd0;
    io_req_wdata = 32'h0;
    io_req_mask  = 4'h0;
    model_clear();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, io_req_ready}, 32'h0);
    chk("rst_busy", {31'b0, io_busy}, 32'h1);
    chk("rst_resp_valid", {31'b0, io_resp_valid}, 32'h0);
    chk("rst_resp_data", io_resp_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_sweep("sweep0");
    read_all_zero();

    // table of single-op vectors, issued back to back
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].exp);
    end
    idle(2);

    // back-to-back hazard on word 1
    send(2'd1, 3'd1, 32'h000000AB, 4'h1, 32'h00000000);
    send(2'd1, 3'd1, 32'h0000CD00, 4'h2, 32'h000000AB);
    send(2'd0, 3'd1, 32'h00000000, 4'h0, 32'h0000CDAB);
    // KEEP right after WRITE on one address, then READ
    send(2'd1, 3'd7, 32'hCAFEF00D, 4'hF, 32'h00000000);
    send(2'd2, 3'd7, 32'h00000000, 4'hA, 32'hCAFEF00D);
    send(2'd0, 3'd7, 32'h00000000, 4'h0, 32'hCA00F000);
    idle(2);

    // random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic [3:0]  mk;
      op   = 2'($urandom_range(0, 3));
      addr = 3'($urandom_range(0, 7));
      wd   = $urandom;
      mk   = 4'($urandom_range(0, 15));
      send(op, addr, wd, mk, model[addr]);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // reset mid-sweep at count 4
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_sweep("sweep_restart");
    read_all_zero();
    idle(2);

    // reset in RUN while a write sits in stage 2
    send(2'd1, 3'd6, 32'h12345678, 4'hF, 32'h00000000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    wait_sweep("sweep_run_reset");
    read_all_zero();

    idle(4);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rmw_mask_mem.md
Name: rmw_mask_mem

Overview:
- Parametrised single-port memory with byte-masked read-modify-write and a valid/ready request interface.
- Successor to the single-cycle conditional masked-write memory. Adds configurable width and depth, three op modes, a registered read port, same-address hazard forwarding, and a post-reset zeroing sweep.
- Sits between a core-side request source and local scratch storage.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; must be a power of 2 and at least 2.
- ADDR_W, log2(DEPTH), address width; derived, not overridden.
- NB, DATA_W/8, byte lanes; derived.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- io_req_valid  input  1  request present.
- io_req_ready  output  1  block accepts a request this cycle.
- io_req_op  input  2  operation: 0 READ, 1 WRITE (merge), 2 KEEP (old AND mask), 3 reserved, treated as READ.
- io_req_addr  input  ADDR_W  word address.
- io_req_wdata  input  DATA_W  write data for WRITE.
- io_req_mask  input  NB  byte enables; bit i covers bits [8i+7:8i].
- io_resp_valid  output  1  response pulse.
- io_resp_data  output  DATA_W  pre-operation contents of the addressed word.
- io_busy  output  1  zeroing sweep in progress.

Behaviour:
- Reset (reset low at a clock edge):
  - State goes to SWEEP; sweep counter = 0.
  - io_req_ready = 0, io_resp_valid = 0, io_resp_data = 0, io_busy = 1.
  - Pipeline valid bit cleared.
- SWEEP state:
  - Writes 0 to word[counter] each cycle; counter increments.
  - After the write to word DEPTH-1, next state is RUN: io_busy = 0, io_req_ready = 1.
  - Sweep takes exactly DEPTH cycles after reset deasserts.
  - Reset asserted mid-sweep restarts the sweep at 0.
- RUN state:
  - io_req_ready = 1 constantly; throughput is one request per cycle.
  - Request accepted when io_req_valid and io_req_ready are both 1 at the edge.
- Pipeline:
  - Stage 1, acceptance edge: addr, op, wdata and mask are registered, and the array is read synchronously at addr.
  - Stage 2, next cycle: old = forwarded value or array value. Response is driven (io_resp_valid = 1, io_resp_data = old), and the write is performed at the end of this cycle.
  - Read latency is 1 cycle from acceptance to io_resp_valid.
- Merge rules, with M = mask expanded to DATA_W:
  - READ: no write.
  - WRITE: new = (wdata AND M) OR (old AND NOT M).
  - KEEP: new = old AND M.
  - Write is skipped when mask == 0 or op is READ/reserved.
- Forwarding:
  - If the stage-1 address equals the stage-2 address and stage 2 writes, the stage-1 old value is the stage-2 new value, not the array value.
  - Back-to-back RMW on one address must therefore compose correctly.
- io_resp_valid:
  - Exactly one pulse per accepted request; low in all other cycles.
  - io_resp_data holds its last value while io_resp_valid is low.
- Reset in RUN with a request in stage 2: the pending write is dropped and the sweep overwrites all words.
- Addresses are always in range; no wrap or bounds logic.

Test Plan:
- Deassert reset -> io_busy = 1 for exactly DEPTH (8) cycles, then io_req_ready = 1; READ of each address 0..7 returns 0x00000000.
- WRITE addr 3, wdata 0xAABBCCDD, mask 0xF, then READ addr 3 -> READ response 0xAABBCCDD, one cycle after its acceptance.
- Word 5 = 0x11223344; WRITE addr 5, wdata 0xFFFFFFFF, mask 0x5 -> response 0x11223344; subsequent READ returns 0x11FF33FF.
- Word 2 = 0xDEADBEEF; KEEP addr 2, mask 0x3 -> response 0xDEADBEEF; subsequent READ returns 0x0000BEEF.
- Back-to-back hazard: word 1 = 0; WRITE addr 1 wdata 0x000000AB mask 0x1, next cycle WRITE addr 1 wdata 0x0000CD00 mask 0x2 -> responses 0x00000000 then 0x000000AB; final READ 0x0000CDAB.
- Reset asserted mid-sweep at count 4, and again in RUN with a write pending -> sweep restarts (busy for 8 more cycles); all words read 0; no stray io_resp_valid.
